// File: rtl/led_pkg.sv
// Shared types and defaults for the LED serial receiver.
package led_pkg;

    localparam int LED_DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/led_rx_hold.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
// Latency: word presented the cycle after in_vld.
// Backpressure: none upstream; a new word overwrites an unconsumed one and sets overrun.
module led_rx_hold #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              overrun
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (in_vld) begin
            // A word still pending and not taken this edge is lost.
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
            out_data  <= in_dat;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/led_serial_rx.sv
// Serial LED frame receiver: latch-framed, MSB-first shift into a DATA_W word.
// Latency: out_valid rises the cycle after bit 0 is sampled. Optional err_cnt via LED_RX_ERR_CNT_EN.
// Backpressure: none on the serial side; unconsumed words are overwritten (overrun).
module led_serial_rx
    import led_pkg::*;
#(
    parameter int DATA_W     = LED_DATA_W,
    parameter int SWAP_BYTES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdi,
    input  logic              latch,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun
`ifdef LED_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int HALF  = DATA_W / 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    rx_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] sr, sr_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic              done;
    logic              err_nxt;
    logic [DATA_W-1:0] word_dat;

    assign bit_idx = IDX_W'(DATA_W - 1) - cnt[IDX_W-1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        done      = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (latch) begin
                    sr_nxt    = {sdi, {(DATA_W-1){1'b0}}};
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (latch) begin
                    // Early latch: drop the partial word and restart on this bit.
                    err_nxt = 1'b1;
                    sr_nxt  = {sdi, {(DATA_W-1){1'b0}}};
                    cnt_nxt = CNT_W'(1);
                end else begin
                    sr_nxt[bit_idx] = sdi;
                    if (cnt == LAST_CNT) begin
                        done      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sr        <= sr_nxt;
            frame_err <= err_nxt;
        end
    end

`ifdef LED_RX_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_nxt && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

    generate
        if (SWAP_BYTES != 0) begin : g_swap
            assign word_dat = {sr_nxt[HALF-1:0], sr_nxt[DATA_W-1:HALF]};
        end else begin : g_noswap
            assign word_dat = sr_nxt;
        end
    endgenerate

    led_rx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (done),
        .in_dat    (word_dat),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_led_serial_rx.sv
// Bench for led_serial_rx: swapping and non-swapping instances share one stimulus,
// checked each cycle against a bit-queue model plus hand-computed literals.
module tb_led_serial_rx;
    import led_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         sdi;
    logic         latch;
    logic         out_ready;
    logic [W-1:0] out_data, out_data0;
    logic         out_valid, out_valid0;
    logic         frame_err, frame_err0;
    logic         overrun, overrun0;
`ifdef LED_RX_ERR_CNT_EN
    logic [7:0]   err_cnt, err_cnt0;
`endif

    always #5 clk = ~clk;

    led_serial_rx #(.DATA_W(W), .SWAP_BYTES(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sdi       (sdi),
        .latch     (latch),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef LED_RX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    led_serial_rx #(.DATA_W(W), .SWAP_BYTES(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .sdi       (sdi),
        .latch     (latch),
        .out_data  (out_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .frame_err (frame_err0),
        .overrun   (overrun0)
`ifdef LED_RX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt0)
`endif
    );

    // Model: bits collected since the last latch; a word exists once W bits are in.
    logic         m_bits[$];
    logic         m_in_frame;
    logic         m_valid;
    logic         m_ovr;
    logic         m_err;
    logic [W-1:0] m_word;
    int           m_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    function automatic logic [W-1:0] swap_w(input logic [W-1:0] w);
        return {w[W/2-1:0], w[W-1:W/2]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_in_frame = 1'b0;
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
        m_err      = 1'b0;
        m_word     = '0;
        m_cnt      = 0;
    endtask

    task automatic model_step();
        logic         got;
        logic [W-1:0] w;
        got   = 1'b0;
        w     = '0;
        m_err = 1'b0;
        if (latch) begin
            if (m_in_frame) m_err = 1'b1;
            m_bits.delete();
            m_bits.push_back(sdi);
            m_in_frame = 1'b1;
        end else if (m_in_frame) begin
            m_bits.push_back(sdi);
            if (m_bits.size() == W) begin
                foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
                got = 1'b1;
                m_bits.delete();
                m_in_frame = 1'b0;
            end
        end
        if (m_err && m_cnt < 255) m_cnt++;
        if (got) begin
            if (m_valid && !out_ready) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_word  = w;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        if (frame_err) err_seen++;
        chk("valid",     16'(out_valid),  16'(m_valid));
        chk("data",      out_data,        swap_w(m_word));
        chk("overrun",   16'(overrun),    16'(m_ovr));
        chk("frame_err", 16'(frame_err),  16'(m_err));
        chk("valid0",    16'(out_valid0), 16'(m_valid));
        chk("data0",     out_data0,       m_word);
        chk("overrun0",  16'(overrun0),   16'(m_ovr));
        chk("frame_err0",16'(frame_err0), 16'(m_err));
`ifdef LED_RX_ERR_CNT_EN
        chk("err_cnt",   16'(err_cnt),    16'(m_cnt));
        chk("err_cnt0",  16'(err_cnt0),   16'(m_cnt));
`endif
    endtask

    // One clock cycle: apply inputs, check mid-cycle, advance the model on the edge.
    task automatic drive(input logic l, input logic s);
        latch = l;
        sdi   = s;
        @(negedge clk);
        if (rst) model_reset();
        compare_all();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) drive(i == 0, w[W-1-i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int e0;
        rst       = 1'b1;
        latch     = 1'b0;
        sdi       = 1'b0;
        out_ready = 1'b1;
        model_reset();
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_data",  out_data,       16'h0);
        rst = 1'b0;
        drive(1'b0, 1'b1);

        // Single frame, consumer ready: one-cycle valid with halves swapped.
        send_bits(16'h1234, 16);
        chk("t1_valid", 16'(out_valid), 16'h1);
        chk("t1_data",  out_data,       16'h3412);
        chk("t1_data0", out_data0,      16'h1234);
        drive(1'b0, 1'b0);
        chk("t1_valid_drop", 16'(out_valid), 16'h0);

        // Back-to-back frames with no consumer: second overwrites, overrun sticks.
        out_ready = 1'b0;
        send_bits(16'hA55A, 16);
        send_bits(16'h0FF0, 16);
        chk("t2_data",    out_data,       16'hF00F);
        chk("t2_valid",   16'(out_valid), 16'h1);
        chk("t2_overrun", 16'(overrun),   16'h1);
        out_ready = 1'b1;
        drive(1'b0, 1'b0);
        chk("t2_overrun_sticky", 16'(overrun), 16'h1);
        do_reset();
        chk("t2_overrun_clr", 16'(overrun), 16'h0);

        // Early latch after 7 bits, then a full frame.
        e0 = err_seen;
        send_bits(16'hFFFF, 7);
        send_bits(16'hBEEF, 16);
        chk("t3_data", out_data, 16'hEFBE);
        drive(1'b0, 1'b0);
        chk("t3_err_pulses", 16'(err_seen - e0), 16'h1);
`ifdef LED_RX_ERR_CNT_EN
        chk("t3_err_cnt", 16'(err_cnt), 16'h1);
`endif

        // Handshake on the same edge a new word completes.
        out_ready = 1'b0;
        send_bits(16'h1357, 16);
        send_bits(16'h2468, 15);
        out_ready = 1'b1;
        drive(1'b0, 1'b0);
        chk("t4_valid",   16'(out_valid), 16'h1);
        chk("t4_data",    out_data,       16'h6824);
        chk("t4_overrun", 16'(overrun),   16'h0);
        drive(1'b0, 1'b0);
        chk("t4_valid_drop", 16'(out_valid), 16'h0);

        // Reset after 9 bits, stray sdi without latch, then a clean frame.
        e0 = err_seen;
        send_bits(16'hABCD, 9);
        rst = 1'b1;
        drive(1'b0, 1'b1);
        chk("t5_rst_valid", 16'(out_valid), 16'h0);
        drive(1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        chk("t5_no_word", 16'(out_valid), 16'h0);
        send_bits(16'h00FF, 16);
        chk("t5_data",  out_data,       16'hFF00);
        chk("t5_valid", 16'(out_valid), 16'h1);
        drive(1'b0, 1'b0);
        chk("t5_no_err", 16'(err_seen - e0), 16'h0);

        // Non-swapping instance passes the word through.
        send_bits(16'h8001, 16);
        chk("t6_data0", out_data0, 16'h8001);
        chk("t6_data",  out_data,  16'h0180);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
